// File: rtl/uart_frame_check_if.sv
// uart_frame_check_if: handshake and status bundle for the UART frame checker
// master: drives start/bit_vld/sampled_bit/par_en/par_typ/stop_two/clr_cnt
// slave : returns p_data/data_vld/par_err/stp_err/busy/par_err_cnt/stp_err_cnt
interface uart_frame_check_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) ();
   logic                  start;
   logic                  bit_vld;
   logic                  sampled_bit;
   logic                  par_en;
   logic [1:0]            par_typ;
   logic                  stop_two;
   logic                  clr_cnt;
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_vld;
   logic                  par_err;
   logic                  stp_err;
   logic                  busy;
   logic [CNT_WIDTH-1:0]  par_err_cnt;
   logic [CNT_WIDTH-1:0]  stp_err_cnt;
   modport master (
      output start, bit_vld, sampled_bit, par_en, par_typ, stop_two, clr_cnt,
      input  p_data, data_vld, par_err, stp_err, busy, par_err_cnt, stp_err_cnt
   );
   modport slave (
      input  start, bit_vld, sampled_bit, par_en, par_typ, stop_two, clr_cnt,
      output p_data, data_vld, par_err, stp_err, busy, par_err_cnt, stp_err_cnt
   );
endinterface

// File: rtl/uart_frame_check.sv
// uart_frame_check: assembles a UART frame from voted bit samples and checks parity/stop bits
// i_clk  : sole clock, rising edge
// i_rst  : asynchronous active-high reset
// io_bus : uart_frame_check_if.slave (frame inputs, data/flag/counter outputs)
// UART_FRAME_ERR_CNT_EN: when defined, adds saturating parity/stop error counters with clr_cnt
module uart_frame_check #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input logic               i_clk,
   input logic               i_rst,
   uart_frame_check_if.slave io_bus
);
   localparam int IW = $clog2(DATA_WIDTH);
   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2, DONE} state_t;
   state_t                r_state, w_next;
   logic [DATA_WIDTH-1:0] r_shift, r_p_data;
   logic [IW-1:0]         r_idx;
   logic                  r_xor, r_par_en, r_stop_two, r_par_bad, r_stp_bad;
   logic [1:0]            r_par_typ;
   logic                  r_par_err, r_stp_err;
   logic                  w_start, w_bit, w_last, w_exp_par, w_stop_chk, w_done;
   // start is ignored only in DONE; a simultaneous bit_vld is always dropped
   assign w_start    = io_bus.start && (r_state != DONE);
   assign w_bit      = io_bus.bit_vld && !io_bus.start;
   assign w_last     = r_idx == IW'(DATA_WIDTH - 1);
   // par_typ[1] selects fixed mark/space, par_typ[0] inverts (odd) or picks space
   assign w_exp_par  = r_par_typ[1] ? ~r_par_typ[0] : r_xor ^ r_par_typ[0];
   assign w_stop_chk = w_bit && (r_state == STOP1 || r_state == STOP2);
   assign w_done     = (w_next == DONE) && (r_state != DONE);
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = IDLE;
         DATA:    if (w_bit && w_last) w_next = r_par_en ? PARITY : STOP1;
         PARITY:  if (w_bit) w_next = STOP1;
         STOP1:   if (w_bit) w_next = r_stop_two ? STOP2 : DONE;
         STOP2:   if (w_bit) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (w_start) w_next = DATA;
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) r_state <= IDLE;
      else r_state <= w_next;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_shift    <= '0;
         r_idx      <= '0;
         r_xor      <= 1'b0;
         r_par_en   <= 1'b0;
         r_par_typ  <= 2'b00;
         r_stop_two <= 1'b0;
         r_par_bad  <= 1'b0;
         r_stp_bad  <= 1'b0;
         r_p_data   <= '0;
         r_par_err  <= 1'b0;
         r_stp_err  <= 1'b0;
      end else begin
         if (w_start) begin
            r_idx      <= '0;
            r_xor      <= 1'b0;
            r_par_bad  <= 1'b0;
            r_stp_bad  <= 1'b0;
            r_par_en   <= io_bus.par_en;
            r_par_typ  <= io_bus.par_typ;
            r_stop_two <= io_bus.stop_two;
         end else if (w_bit) begin
            if (r_state == DATA) begin
               r_shift[r_idx] <= io_bus.sampled_bit;
               r_xor          <= r_xor ^ io_bus.sampled_bit;
               r_idx          <= r_idx + 1'b1;
            end
            if (r_state == PARITY) r_par_bad <= io_bus.sampled_bit != w_exp_par;
            if (w_stop_chk) r_stp_bad <= r_stp_bad | ~io_bus.sampled_bit;
         end
         // results are published as the FSM enters DONE, so they are visible on the data_vld cycle
         if (w_done) begin
            r_p_data  <= r_shift;
            r_par_err <= r_par_bad;
            r_stp_err <= r_stp_bad | ~io_bus.sampled_bit;
         end
      end
   end
   assign io_bus.p_data   = r_p_data;
   assign io_bus.data_vld = r_state == DONE;
   assign io_bus.par_err  = r_par_err;
   assign io_bus.stp_err  = r_stp_err;
   assign io_bus.busy     = r_state != IDLE;
`ifdef UART_FRAME_ERR_CNT_EN
   localparam logic [CNT_WIDTH-1:0] CMAX = '1;
   logic [CNT_WIDTH-1:0] r_par_cnt, r_stp_cnt;
   // counts use the flags already registered for the DONE cycle; clear takes priority
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst || io_bus.clr_cnt) begin
         r_par_cnt <= '0;
         r_stp_cnt <= '0;
      end else if (r_state == DONE) begin
         if (r_par_err && r_par_cnt != CMAX) r_par_cnt <= r_par_cnt + 1'b1;
         if (r_stp_err && r_stp_cnt != CMAX) r_stp_cnt <= r_stp_cnt + 1'b1;
      end
   end
   assign io_bus.par_err_cnt = r_par_cnt;
   assign io_bus.stp_err_cnt = r_stp_cnt;
`else
   logic w_unused_clr;
   assign w_unused_clr       = io_bus.clr_cnt;
   assign io_bus.par_err_cnt = '0;
   assign io_bus.stp_err_cnt = '0;
`endif
endmodule

// File: tb/tb_uart_frame_check.sv
// tb_uart_frame_check: scoreboard bench for uart_frame_check with directed frames
module tb_uart_frame_check;
   localparam int DW = 8;
   localparam int CW = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   uart_frame_check_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
   uart_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );
   typedef struct {
      logic [DW-1:0] data;
      logic          pe;
      logic          se;
      int            cyc;
   } exp_t;
   exp_t q[$];
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [CW-1:0] m_pc = '0;
   logic [CW-1:0] m_sc = '0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin : mon
      exp_t e;
      logic pe, se;
      pe = 1'b0;
      se = 1'b0;
      if (rst) begin
         m_pc = '0;
         m_sc = '0;
      end
      chk("par_err_cnt", 32'(bus.par_err_cnt), 32'(m_pc));
      chk("stp_err_cnt", 32'(bus.stp_err_cnt), 32'(m_sc));
      if (bus.data_vld) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected data_vld: got p_data %0h, required no frame output (t=%0t)", bus.p_data, $time);
         end else begin
            e = q.pop_front();
            chk("p_data", 32'(bus.p_data), 32'(e.data));
            chk("par_err", 32'(bus.par_err), 32'(e.pe));
            chk("stp_err", 32'(bus.stp_err), 32'(e.se));
            chk("data_vld latency", cyc, e.cyc);
            pe = e.pe;
            se = e.se;
         end
      end
`ifdef UART_FRAME_ERR_CNT_EN
      if (bus.clr_cnt) begin
         m_pc = '0;
         m_sc = '0;
      end else begin
         if (pe && m_pc != {CW{1'b1}}) m_pc = m_pc + 1'b1;
         if (se && m_sc != {CW{1'b1}}) m_sc = m_sc + 1'b1;
      end
`endif
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send_bit(input logic b);
      bus.bit_vld = 1'b1;
      bus.sampled_bit = b;
      tick();
      bus.bit_vld = 1'b0;
      bus.sampled_bit = 1'b0;
      tick();
   endtask
   // start carries a simultaneous bit_vld=1 that must be discarded; config is scrambled after capture
   task automatic start_frame(input logic pe, input logic [1:0] pt, input logic st);
      bus.start = 1'b1;
      bus.bit_vld = 1'b1;
      bus.sampled_bit = 1'b1;
      bus.par_en = pe;
      bus.par_typ = pt;
      bus.stop_two = st;
      tick();
      bus.start = 1'b0;
      bus.bit_vld = 1'b0;
      bus.sampled_bit = 1'b0;
      bus.par_en = ~pe;
      bus.par_typ = ~pt;
      bus.stop_two = ~st;
   endtask
   task automatic frame(input logic [DW-1:0] d, input logic pe, input logic [1:0] pt, input logic st,
                        input logic pb, input logic s1, input logic s2,
                        input logic exp_pe, input logic exp_se, input logic clr);
      exp_t e;
      start_frame(pe, pt, st);
      chk("busy in frame", 32'(bus.busy), 32'd1);
      for (int i = 0; i < DW; i++) send_bit(d[i]);
      if (pe) send_bit(pb);
      if (st) send_bit(s1);
      e.data = d;
      e.pe = exp_pe;
      e.se = exp_se;
      e.cyc = cyc + 1;
      q.push_back(e);
      bus.bit_vld = 1'b1;
      bus.sampled_bit = st ? s2 : s1;
      tick();
      bus.bit_vld = 1'b0;
      bus.sampled_bit = 1'b0;
      bus.clr_cnt = clr;
      tick();
      bus.clr_cnt = 1'b0;
      tick();
      chk("busy after frame", 32'(bus.busy), 32'd0);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.bit_vld = 1'b0;
      bus.sampled_bit = 1'b0;
      bus.par_en = 1'b0;
      bus.par_typ = 2'b00;
      bus.stop_two = 1'b0;
      bus.clr_cnt = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("reset p_data", 32'(bus.p_data), 32'd0);
      chk("reset data_vld", 32'(bus.data_vld), 32'd0);
      chk("reset par_err", 32'(bus.par_err), 32'd0);
      chk("reset stp_err", 32'(bus.stp_err), 32'd0);
      chk("reset busy", 32'(bus.busy), 32'd0);
      //    data   pe    typ    st    pb    s1    s2    epe   ese   clr
      frame(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      frame(8'h03, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      frame(8'h01, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      frame(8'h07, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      frame(8'h5A, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      frame(8'h0F, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      frame(8'h0F, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      frame(8'hC3, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      frame(8'hFF, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      frame(8'h81, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      // bit strobes while idle are ignored
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      chk("busy idle bits", 32'(bus.busy), 32'd0);
      frame(8'h66, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      // abort after four data bits, then a full 0x3C frame
      start_frame(1'b1, 2'b00, 1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      frame(8'h3C, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      // leave error flags set, then reset asynchronously five bits into a frame
      frame(8'hE7, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      start_frame(1'b1, 2'b00, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      rst = 1'b1;
      #1;
      chk("async rst p_data", 32'(bus.p_data), 32'd0);
      chk("async rst data_vld", 32'(bus.data_vld), 32'd0);
      chk("async rst par_err", 32'(bus.par_err), 32'd0);
      chk("async rst stp_err", 32'(bus.stp_err), 32'd0);
      chk("async rst busy", 32'(bus.busy), 32'd0);
      chk("async rst par_cnt", 32'(bus.par_err_cnt), 32'd0);
      chk("async rst stp_cnt", 32'(bus.stp_err_cnt), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) send_bit(1'b1);
      chk("busy after rst", 32'(bus.busy), 32'd0);
      // five parity errors saturate a 2-bit counter, then clear on an erroring data_vld cycle
      for (int i = 0; i < 5; i++)
         frame(8'h03, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      frame(8'h03, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      frame(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("pending frames", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
